comparator_debounce_tracker: RTL and testbench
==============================================

// Module: comparator_debounce_tracker
// PURPOSE
//   Sits directly downstream of the 16-bit comparator and consumes its gt/eq/lt flags.
//   Debounces the flags over DEBOUNCE_COUNT consecutive valid samples and commits a stable relation state.
//   Flags every committed change and any illegal flag combination.
//   Threshold/alarm logic reads its outputs instead of the raw comparator flags.
// PARAMETERS
//   DEBOUNCE_COUNT  4   consecutive identical valid samples needed to commit; legal range 1..255
//   RUN_WIDTH       8   width of the internal run counter; must hold DEBOUNCE_COUNT
//   COUNT_WIDTH     16  width of the event counters (COMPARE_EVENT_COUNT_EN only)
// PORTS
//   Clock_In          in   1            sole clock, rising edge
//   Reset_In          in   1            synchronous, active-high reset
//   Enable_In         in   1            tracker enable; also drives the comparator Enable_In
//   Clear_In          in   1            synchronous soft clear, same effect as reset
//   Sample_Valid_In   in   1            the current flags are a sample
//   A_gt_B_In         in   1            comparator greater-than flag
//   A_eq_B_In         in   1            comparator equal flag
//   A_lt_B_In         in   1            comparator less-than flag
//   State_Out         out  2            00 UNKNOWN, 01 LT, 10 EQ, 11 GT
//   State_Valid_Out   out  1            high when State_Out != UNKNOWN
//   Change_Pulse_Out  out  1            one-cycle pulse on each committed state change
//   Error_Out         out  1            sticky; set by an illegal flag sample
//   Rise_Count_Out    out  COUNT_WIDTH  upward commits (macro only)
//   Fall_Count_Out    out  COUNT_WIDTH  downward commits (macro only)
// BEHAVIOUR
//   - Reset and Clear:
//     - All registers update on the rising edge of Clock_In.
//     - Reset_In and Clear_In are synchronous, with priority Reset_In > Clear_In > sampling.
//     - Reset values: State_Out=00, State_Valid_Out=0, Change_Pulse_Out=0, Error_Out=0, all counters=0, candidate=UNKNOWN, run=0.
//     - Reset mid-debounce discards the partial run.
//   - Sampling:
//     - A sample is taken only when Enable_In=1 and Sample_Valid_In=1.
//     - Idle cycles (Sample_Valid_In=0) do not break a run.
//     - Enable_In=0 clears run to 0 and holds State_Out.
//     - This covers the comparator driving Z while disabled.
//   - Sample classification:
//     - Exactly one flag high gives class GT, EQ or LT.
//     - Any other pattern (none, more than one, X or Z) is illegal.
//     - An illegal sample sets Error_Out, clears run to 0 and leaves State_Out unchanged.
//   - Run counting:
//     - If the sample class equals the candidate, run increments, saturating at DEBOUNCE_COUNT.
//     - Otherwise candidate takes the sample class and run is set to 1.
//   - Commit:
//     - Commit happens on the edge of the sample that makes run == DEBOUNCE_COUNT, when candidate != State_Out.
//     - State_Out takes the candidate.
//     - Change_Pulse_Out is high for exactly the following cycle.
//     - Latency is the Nth qualifying sample edge; there is no further pipeline delay.
//   - State machine: UNKNOWN -> {LT, EQ, GT} on the first commit. Any stable state can move to any other stable state on commit.
//     UNKNOWN is re-entered only by reset or Clear_In.
//   - DEBOUNCE_COUNT=1: every valid sample whose class differs from State_Out commits immediately.
//   - Change_Pulse_Out is never high for two consecutive cycles unless two commits occur back to back.
// CONFIGURATION
//   COMPARE_EVENT_COUNT_EN defined:
//     - Rise_Count_Out and Fall_Count_Out exist.
//     - Order is LT < EQ < GT. A commit to a higher state increments Rise; a commit to a lower state increments Fall.
//     - Commits out of UNKNOWN are not counted.
//     - Both counters saturate at all-ones and are cleared by reset or Clear_In.
//   COMPARE_EVENT_COUNT_EN undefined: both ports and their logic are absent; all other behaviour is identical.
// TESTING
//   1. Reset_In=1 for 2 cycles with random flags -> State_Out=00, State_Valid_Out=0, Change_Pulse_Out=0, Error_Out=0.
//   2. DEBOUNCE_COUNT=4: GT x4 (gaps of 0-3 idle cycles) -> State_Out=11 after the 4th sample, one Change pulse.
//      GT x3 then LT -> no change.
//   3. Committed LT; samples GT,GT,LT,GT,GT,GT -> State_Out stays 01, no pulse; one more GT -> State_Out=11, one pulse.
//   4. gt=eq=1, or Enable_In=1 while the flags are Z -> Error_Out=1 and stays set, state held.
//      Clear_In for 1 cycle -> Error_Out=0, State_Out=00.
//   5. Reset_In or Enable_In=0 asserted after 3 GT samples, then 3 more GT -> no commit until the 4th post-event sample.
//   6. With macro: LT->GT->EQ->GT -> Rise=2, Fall=1. COUNT_WIDTH=2 with 5 rises -> Rise_Count_Out=3.

Source files
------------

// File: rtl/comparator_debounce_tracker_if.sv
// Flag inputs and tracker outputs between the comparator side and the debounce tracker.
// COMPARE_EVENT_COUNT_EN adds the rise/fall event counter outputs.
interface comparator_debounce_tracker_if
`ifdef COMPARE_EVENT_COUNT_EN
  #(parameter int unsigned COUNT_WIDTH = 16)
`endif
  ;
  logic       Enable_In;
  logic       Clear_In;
  logic       Sample_Valid_In;
  logic       A_gt_B_In;
  logic       A_eq_B_In;
  logic       A_lt_B_In;
  logic [1:0] State_Out;
  logic       State_Valid_Out;
  logic       Change_Pulse_Out;
  logic       Error_Out;
`ifdef COMPARE_EVENT_COUNT_EN
  logic [COUNT_WIDTH-1:0] Rise_Count_Out;
  logic [COUNT_WIDTH-1:0] Fall_Count_Out;

  modport master (
    output Enable_In, Clear_In, Sample_Valid_In, A_gt_B_In, A_eq_B_In, A_lt_B_In,
    input  State_Out, State_Valid_Out, Change_Pulse_Out, Error_Out,
    input  Rise_Count_Out, Fall_Count_Out
  );

  modport slave (
    input  Enable_In, Clear_In, Sample_Valid_In, A_gt_B_In, A_eq_B_In, A_lt_B_In,
    output State_Out, State_Valid_Out, Change_Pulse_Out, Error_Out,
    output Rise_Count_Out, Fall_Count_Out
  );
`else
  modport master (
    output Enable_In, Clear_In, Sample_Valid_In, A_gt_B_In, A_eq_B_In, A_lt_B_In,
    input  State_Out, State_Valid_Out, Change_Pulse_Out, Error_Out
  );

  modport slave (
    input  Enable_In, Clear_In, Sample_Valid_In, A_gt_B_In, A_eq_B_In, A_lt_B_In,
    output State_Out, State_Valid_Out, Change_Pulse_Out, Error_Out
  );
`endif
endinterface

// File: rtl/comparator_debounce_tracker.sv
// Debounces comparator gt/eq/lt flags into a committed relation state with change/error flags.
// COMPARE_EVENT_COUNT_EN adds saturating rise/fall commit counters.
module comparator_debounce_tracker #(
`ifdef COMPARE_EVENT_COUNT_EN
  parameter int unsigned COUNT_WIDTH    = 16,
`endif
  parameter int unsigned DEBOUNCE_COUNT = 4,
  parameter int unsigned RUN_WIDTH      = 8
) (
  input logic                          Clock_In,
  input logic                          Reset_In,
  comparator_debounce_tracker_if.slave bus
);

  // Encoding order matches relation order, so magnitude compare gives rise/fall.
  typedef enum logic [1:0] {
    StUnknown = 2'b00,
    StLt      = 2'b01,
    StEq      = 2'b10,
    StGt      = 2'b11
  } state_e;

  localparam logic [RUN_WIDTH-1:0] RunTarget = RUN_WIDTH'(DEBOUNCE_COUNT);
  localparam logic [RUN_WIDTH-1:0] RunOne    = RUN_WIDTH'(1);

  if (DEBOUNCE_COUNT < 1 || DEBOUNCE_COUNT > 255 ||
      DEBOUNCE_COUNT >= (64'd1 << RUN_WIDTH)) begin : g_bad_param
    $error("DEBOUNCE_COUNT out of range or does not fit in RUN_WIDTH");
  end

  state_e               state_q, state_d;
  state_e               cand_q, cand_d;
  logic [RUN_WIDTH-1:0] run_q, run_d;
  logic                 change_q, change_d;
  logic                 error_q, error_d;

  logic   [2:0] flags;
  logic         flags_legal;
  state_e       sample_cls;
  logic         sample_take;
  logic         commit;

  assign flags       = {bus.A_gt_B_In, bus.A_eq_B_In, bus.A_lt_B_In};
  assign sample_take = bus.Enable_In & bus.Sample_Valid_In;

  // Non-matching patterns (including X/Z) fall into default and are illegal.
  always_comb begin
    flags_legal = 1'b1;
    sample_cls  = StUnknown;
    case (flags)
      3'b100:  sample_cls = StGt;
      3'b010:  sample_cls = StEq;
      3'b001:  sample_cls = StLt;
      default: flags_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    run_d   = run_q;
    error_d = error_q;
    commit  = 1'b0;

    if (!bus.Enable_In) begin
      run_d = '0;
    end else if (sample_take) begin
      if (!flags_legal) begin
        error_d = 1'b1;
        run_d   = '0;
      end else begin
        if (sample_cls == cand_q) begin
          if (run_q < RunTarget) begin
            run_d = run_q + RunOne;
          end
        end else begin
          cand_d = sample_cls;
          run_d  = RunOne;
        end
        if (run_d == RunTarget && cand_d != state_q) begin
          commit  = 1'b1;
          state_d = cand_d;
        end
      end
    end

    change_d = commit;
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q  <= StUnknown;
      cand_q   <= StUnknown;
      run_q    <= '0;
      change_q <= 1'b0;
      error_q  <= 1'b0;
    end else if (bus.Clear_In) begin
      state_q  <= StUnknown;
      cand_q   <= StUnknown;
      run_q    <= '0;
      change_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      change_q <= change_d;
      error_q  <= error_d;
    end
  end

  assign bus.State_Out        = state_q;
  assign bus.State_Valid_Out  = (state_q != StUnknown);
  assign bus.Change_Pulse_Out = change_q;
  assign bus.Error_Out        = error_q;

`ifdef COMPARE_EVENT_COUNT_EN
  logic [COUNT_WIDTH-1:0] rise_q, rise_d;
  logic [COUNT_WIDTH-1:0] fall_q, fall_d;

  // Leaving UNKNOWN is not an event; only moves between stable states count.
  always_comb begin
    rise_d = rise_q;
    fall_d = fall_q;
    if (commit && state_q != StUnknown) begin
      if (state_d > state_q) begin
        if (rise_q != '1) begin
          rise_d = rise_q + COUNT_WIDTH'(1);
        end
      end else if (fall_q != '1) begin
        fall_d = fall_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      rise_q <= '0;
      fall_q <= '0;
    end else if (bus.Clear_In) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.Rise_Count_Out = rise_q;
  assign bus.Fall_Count_Out = fall_q;
`endif

endmodule

// File: tb/tb_comparator_debounce_tracker.sv
// Directed + randomized bench for comparator_debounce_tracker against a history-queue model.
// Build with COMPARE_EVENT_COUNT_EN to also exercise the event counters (COUNT_WIDTH=2).
module tb_comparator_debounce_tracker;
  localparam int N = 4;
`ifdef COMPARE_EVENT_COUNT_EN
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef COMPARE_EVENT_COUNT_EN
  comparator_debounce_tracker_if #(.COUNT_WIDTH(CW)) bus ();
`else
  comparator_debounce_tracker_if bus ();
`endif

  comparator_debounce_tracker #(
`ifdef COMPARE_EVENT_COUNT_EN
    .COUNT_WIDTH   (CW),
`endif
    .DEBOUNCE_COUNT(N),
    .RUN_WIDTH     (8)
  ) dut (
    .Clock_In(clk),
    .Reset_In(rst),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  // Reference model: last legal samples since the last break; commit when N agree.
  int m_state = 0;
  int m_err   = 0;
  int m_pulse = 0;
  int m_rise  = 0;
  int m_fall  = 0;
  int hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] flags_of(input int c);
    case (c)
      3:       return 3'b100;
      2:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic model_edge();
    logic [2:0] f;
    int cls;
    bit same;
    f = {bus.A_gt_B_In, bus.A_eq_B_In, bus.A_lt_B_In};
    if (rst || bus.Clear_In) begin
      m_state = 0; m_err = 0; m_pulse = 0; m_rise = 0; m_fall = 0;
      hist.delete();
      return;
    end
    m_pulse = 0;
    if (!bus.Enable_In) begin
      hist.delete();
    end else if (bus.Sample_Valid_In) begin
      if ($isunknown(f) || $countones(f) != 1) begin
        m_err = 1;
        hist.delete();
      end else begin
        cls = f[2] ? 3 : (f[1] ? 2 : 1);
        hist.push_back(cls);
        if (hist.size() > N) void'(hist.pop_front());
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != cls) same = 1'b0;
        if (hist.size() == N && same && cls != m_state) begin
          if (m_state != 0) begin
            if (cls > m_state) m_rise = (m_rise < 65535) ? m_rise + 1 : m_rise;
            else               m_fall = (m_fall < 65535) ? m_fall + 1 : m_fall;
          end
          m_state = cls;
          m_pulse = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("state", 32'(bus.State_Out), 32'(m_state));
    chk("state_valid", 32'(bus.State_Valid_Out), 32'(m_state != 0));
    chk("change_pulse", 32'(bus.Change_Pulse_Out), 32'(m_pulse));
    chk("error", 32'(bus.Error_Out), 32'(m_err));
`ifdef COMPARE_EVENT_COUNT_EN
    chk("rise_count", 32'(bus.Rise_Count_Out), 32'((m_rise > CMAX) ? CMAX : m_rise));
    chk("fall_count", 32'(bus.Fall_Count_Out), 32'((m_fall > CMAX) ? CMAX : m_fall));
`endif
  endtask

  task automatic drive(input logic r, input logic c, input logic e, input logic v,
                       input logic [2:0] f);
    rst = r;
    bus.Clear_In = c;
    bus.Enable_In = e;
    bus.Sample_Valid_In = v;
    bus.A_gt_B_In = f[2];
    bus.A_eq_B_In = f[1];
    bus.A_lt_B_In = f[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (bus.Change_Pulse_Out) pulse_cnt++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 3'($urandom));
      tick();
    end
  endtask

  // n valid samples of class c, each preceded by 0..maxgap idle cycles
  task automatic samples(input int c, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      idle(int'($urandom_range(maxgap, 0)));
      drive(1'b0, 1'b0, 1'b1, 1'b1, flags_of(c));
      tick();
    end
  endtask

  task automatic clear_pulse();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    tick();
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);

    // Reset with random flags
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      tick();
    end
    chk("rst_state", 32'(bus.State_Out), 32'd0);
    chk("rst_valid", 32'(bus.State_Valid_Out), 32'd0);
    chk("rst_pulse", 32'(bus.Change_Pulse_Out), 32'd0);
    chk("rst_error", 32'(bus.Error_Out), 32'd0);

    // GT x3 then LT: no commit
    pulse_cnt = 0;
    samples(3, 3, 3);
    samples(1, 1, 3);
    chk("gt3_lt_no_commit", 32'(bus.State_Out), 32'd0);
    // GT x4 with gaps: commit on the 4th
    samples(3, 3, 3);
    chk("gt3_still_unknown", 32'(bus.State_Out), 32'd0);
    samples(3, 1, 3);
    chk("gt4_commit", 32'(bus.State_Out), 32'd3);
    chk("gt4_pulse_now", 32'(bus.Change_Pulse_Out), 32'd1);
    idle(2);
    chk("gt4_one_pulse", 32'(pulse_cnt), 32'd1);

    // Committed LT; interrupted GT run then a full one
    samples(1, 4, 1);
    chk("lt_commit", 32'(bus.State_Out), 32'd1);
    idle(1);
    pulse_cnt = 0;
    samples(3, 2, 1);
    samples(1, 1, 1);
    samples(3, 3, 1);
    chk("broken_run_hold", 32'(bus.State_Out), 32'd1);
    chk("broken_run_no_pulse", 32'(pulse_cnt), 32'd0);
    samples(3, 1, 1);
    chk("full_run_gt", 32'(bus.State_Out), 32'd3);
    idle(1);
    chk("full_run_one_pulse", 32'(pulse_cnt), 32'd1);

    // Illegal gt+eq, then Z flags, then clear
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b110);
    tick();
    chk("illegal_err", 32'(bus.Error_Out), 32'd1);
    chk("illegal_hold", 32'(bus.State_Out), 32'd3);
    idle(3);
    chk("err_sticky", 32'(bus.Error_Out), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    bus.A_gt_B_In = 1'bz;
    bus.A_eq_B_In = 1'bz;
    bus.A_lt_B_In = 1'bz;
    tick();
    chk("z_err", 32'(bus.Error_Out), 32'd1);
    chk("z_hold", 32'(bus.State_Out), 32'd3);
    clear_pulse();
    chk("clear_err", 32'(bus.Error_Out), 32'd0);
    chk("clear_state", 32'(bus.State_Out), 32'd0);

    // Reset mid-run discards the partial run
    samples(3, 3, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b100);
    tick();
    samples(3, 3, 0);
    chk("rst_mid_no_commit", 32'(bus.State_Out), 32'd0);
    samples(3, 1, 0);
    chk("rst_mid_commit", 32'(bus.State_Out), 32'd3);
    // Enable low mid-run discards the partial run
    samples(1, 3, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
    tick();
    samples(1, 3, 0);
    chk("en_low_no_commit", 32'(bus.State_Out), 32'd3);
    samples(1, 1, 0);
    chk("en_low_commit", 32'(bus.State_Out), 32'd1);

`ifdef COMPARE_EVENT_COUNT_EN
    clear_pulse();
    samples(1, 4, 0);
    samples(3, 4, 0);
    samples(2, 4, 0);
    samples(3, 4, 0);
    chk("cnt_rise2", 32'(bus.Rise_Count_Out), 32'd2);
    chk("cnt_fall1", 32'(bus.Fall_Count_Out), 32'd1);
    clear_pulse();
    samples(1, 4, 0);
    for (int k = 0; k < 5; k++) begin
      samples(3, 4, 0);
      samples(1, 4, 0);
    end
    chk("cnt_rise_sat", 32'(bus.Rise_Count_Out), 32'd3);
`endif

    // Randomized runs of classes with occasional idles, illegal samples, enable drops
    for (int it = 0; it < 300; it++) begin
      int c;
      int len;
      c = int'($urandom_range(3, 1));
      len = int'($urandom_range(6, 1));
      for (int j = 0; j < len; j++) begin
        logic r, cl, e, v;
        logic [2:0] f;
        r  = ($urandom_range(199, 0) == 0);
        cl = ($urandom_range(99, 0) == 0);
        e  = ($urandom_range(19, 0) != 0);
        v  = ($urandom_range(3, 0) != 0);
        f  = ($urandom_range(19, 0) == 0) ? 3'($urandom) : flags_of(c);
        drive(r, cl, e, v, f);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
